dma_port_ram: RTL and testbench
===============================

Name: dma_port_ram

Overview:
- Parametrised word-addressed memory serving the DMA loopback's mm2s read port and s2mm write port. It replaces the byte-at-a-time memory model on those ports.
- Adds the following over the fixed single-cycle model:
  - configurable width, depth and read latency;
  - read-valid qualification;
  - selectable read-during-write behaviour;
  - out-of-range detection;
  - transfer statistics.
- Sits between the DMA engine's mm2s/s2mm word ports and the rest of the system, on the single DMA clock.

Parameters:
- AXI_WIDTH, 128, data word width in bits; multiple of 8, power of two, 32..512.
- AXI_ADDR_WIDTH, 32, byte address width of the DMA.
- DEPTH_WORDS, 1024, number of AXI_WIDTH-bit words stored; 2..65536.
- RD_LATENCY, 1, cycles from mm2s_ren to mm2s_valid; legal 1..4.
- RAW_MODE, 0, behaviour when a read and a write hit the same word in the same cycle: 0 = read returns old data, 1 = read returns merged new data.
- Derived localparam: LSB = $clog2(AXI_WIDTH)-3. Word address width is AW = AXI_ADDR_WIDTH-LSB.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- mm2s_ren  in  1  read request, one word
- mm2s_addr  in  AW  read word address (byte address >> LSB)
- mm2s_data  out  AXI_WIDTH  read data
- mm2s_valid  out  1  mm2s_data holds the response to a request
- s2mm_wen  in  1  write request, one word
- s2mm_addr  in  AW  write word address
- s2mm_data  in  AXI_WIDTH  write data
- s2mm_strb  in  AXI_WIDTH/8  byte enables; bit i covers data[8i+7:8i]
- clr_stats  in  1  clears rd_count, wr_count and oob_err
- rd_count  out  32  accepted read requests
- wr_count  out  32  accepted write requests
- oob_err  out  1  sticky: an address >= DEPTH_WORDS was presented

Behaviour:
- Reset values:
  - mm2s_data = 0, mm2s_valid = 0, rd_count = 0, wr_count = 0, oob_err = 0.
  - Memory contents are not reset and are retained across rst.
- Read path:
  - mm2s_ren high at edge t produces mm2s_valid = 1 and the data at edge t+RD_LATENCY.
  - Fully pipelined: back-to-back reads are accepted every cycle, with no stall and no backpressure.
  - mm2s_valid is a RD_LATENCY-deep shift of mm2s_ren.
  - When mm2s_valid = 0, mm2s_data holds its last value.
- Write path:
  - On s2mm_wen, each byte i with s2mm_strb[i] = 1 is written at the edge.
  - Bytes with strb = 0 are unchanged.
  - strb = 0 overall is a legal no-op write; it is still counted.
- Read and write to the same address in the same cycle:
  - RAW_MODE = 0: the read returns the pre-write word.
  - RAW_MODE = 1: the read returns the word merged with the strobed new bytes.
  - Different addresses in the same cycle are independent.
- Out of range (addr >= DEPTH_WORDS):
  - A read still produces mm2s_valid with data = 0.
  - A write is dropped and the memory is unchanged.
  - In either case oob_err is set the following edge.
  - The request is still counted.
- Counters:
  - rd_count increments by 1 per mm2s_ren; wr_count increments by 1 per s2mm_wen.
  - Both saturate at 32'hFFFF_FFFF; there is no wrap.
- clr_stats:
  - Clears rd_count, wr_count and oob_err at the edge.
  - It has priority over events in the same cycle: an event coincident with clr_stats is not counted and does not set oob_err.
- Reset mid-operation:
  - rst flushes the read pipeline; in-flight reads are discarded and never raise mm2s_valid.
  - A write presented in the same cycle as rst is ignored.
  - Requests in the cycle after rst deasserts are served normally.
- DEPTH_WORDS need not be a power of two. The memory index uses $clog2(DEPTH_WORDS) bits after the range check; address upper bits are not silently truncated.

Test Plan:
- Basic write/read, RD_LATENCY=1:
  - Stimulus: write addr 5 = 128'h0011..FF with strb all-ones, then ren addr 5.
  - Required: mm2s_valid = 1 exactly 1 cycle later, data = 128'h0011..FF, wr_count = 1, rd_count = 1.
- Partial strobe:
  - Stimulus: addr 3 preloaded all 0xAA; write strb = 16'h00F0 with data all 0x55; then read.
  - Required: bytes 4..7 = 0x55, all others 0xAA.
- Latency and pipelining, RD_LATENCY=3:
  - Stimulus: preload addrs 0..7 with value = addr; 8 consecutive reads of addrs 0..7.
  - Required: valid high for 8 consecutive cycles starting 3 cycles after the first ren; data 0..7 in order.
- Read-during-write to addr 9, old = 0, new = all-ones:
  - RAW_MODE=0: read returns 0.
  - RAW_MODE=1: read returns all-ones.
  - In both modes, a following read returns all-ones.
- Out of range, DEPTH_WORDS=1000:
  - Stimulus: write addr 1000 with nonzero data, then read addr 1000.
  - Required: read data = 0, oob_err = 1, addr 999 unchanged.
  - Then clr_stats together with another out-of-range read: counts = 0, oob_err = 0.
- Reset mid-read, RD_LATENCY=4:
  - Stimulus: issue 2 reads, assert rst 2 cycles later.
  - Required: no mm2s_valid pulse, counters = 0, previously written data still readable after reset.

Source files
------------

// File: rtl/dma_port_ram.sv
`default_nettype none
// ============================================================================
// Module      : dma_port_ram
// Description : Word-addressed memory for the DMA mm2s read / s2mm write
//               ports, with pipelined reads, byte strobes and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_port_ram #(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int DEPTH_WORDS    = 1024,
    parameter int RD_LATENCY     = 1,
    parameter int RAW_MODE       = 0
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               mm2s_ren,
    input  logic [AXI_ADDR_WIDTH-($clog2(AXI_WIDTH)-3)-1:0]    mm2s_addr,
    output logic [AXI_WIDTH-1:0]                               mm2s_data,
    output logic                                               mm2s_valid,
    input  logic                                               s2mm_wen,
    input  logic [AXI_ADDR_WIDTH-($clog2(AXI_WIDTH)-3)-1:0]    s2mm_addr,
    input  logic [AXI_WIDTH-1:0]                               s2mm_data,
    input  logic [AXI_WIDTH/8-1:0]                             s2mm_strb,
    input  logic                                               clr_stats,
    output logic [31:0]                                        rd_count,
    output logic [31:0]                                        wr_count,
    output logic                                               oob_err
);

    localparam int            c_LSB     = $clog2(AXI_WIDTH) - 3;
    localparam int            c_AW      = AXI_ADDR_WIDTH - c_LSB;
    localparam int            c_NB      = AXI_WIDTH / 8;
    localparam int            c_IW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [c_AW:0] c_DEPTH   = (c_AW+1)'(DEPTH_WORDS);
    localparam logic [31:0]   c_CNT_MAX = '1;
    localparam logic          c_MERGE   = (RAW_MODE != 0);

    logic [AXI_WIDTH-1:0]  r_mem [DEPTH_WORDS];
    logic [RD_LATENCY-1:0] r_vld;
    logic [AXI_WIDTH-1:0]  r_dat [RD_LATENCY];

    logic                  w_rd_inr;
    logic                  w_wr_inr;
    logic                  w_collide;
    logic                  w_oob_evt;
    logic [c_IW-1:0]       w_rd_idx;
    logic [c_IW-1:0]       w_wr_idx;
    logic [AXI_WIDTH-1:0]  w_rd_word;

    // Range check uses the full address so upper bits are never dropped.
    assign w_rd_inr  = ({1'b0, mm2s_addr} < c_DEPTH);
    assign w_wr_inr  = ({1'b0, s2mm_addr} < c_DEPTH);
    assign w_rd_idx  = mm2s_addr[c_IW-1:0];
    assign w_wr_idx  = s2mm_addr[c_IW-1:0];
    assign w_collide = c_MERGE && s2mm_wen && w_wr_inr && (s2mm_addr == mm2s_addr);
    assign w_oob_evt = (mm2s_ren && !w_rd_inr) || (s2mm_wen && !w_wr_inr);

    always_comb begin
        w_rd_word = '0;
        if (w_rd_inr) begin
            w_rd_word = r_mem[w_rd_idx];
            if (w_collide) begin
                for (int i = 0; i < c_NB; i++) begin
                    if (s2mm_strb[i]) begin
                        w_rd_word[8*i +: 8] = s2mm_data[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && s2mm_wen && w_wr_inr) begin
            for (int i = 0; i < c_NB; i++) begin
                if (s2mm_strb[i]) begin
                    r_mem[w_wr_idx][8*i +: 8] <= s2mm_data[8*i +: 8];
                end
            end
        end
    end

    // Each stage only loads on a valid beat, so the last stage holds its data
    // while mm2s_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= mm2s_ren;
            if (mm2s_ren) begin
                r_dat[0] <= w_rd_word;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign mm2s_valid = r_vld[RD_LATENCY-1];
    assign mm2s_data  = r_dat[RD_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            rd_count <= '0;
            wr_count <= '0;
            oob_err  <= 1'b0;
        end else begin
            if (mm2s_ren && (rd_count != c_CNT_MAX)) begin
                rd_count <= rd_count + 32'd1;
            end
            if (s2mm_wen && (wr_count != c_CNT_MAX)) begin
                wr_count <= wr_count + 32'd1;
            end
            if (w_oob_evt) begin
                oob_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_port_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_port_ram
// Description : Scoreboard bench for dma_port_ram over three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_port_ram;

    localparam int c_NI = 3;

    logic              clk;
    logic              rst;
    logic              ren;
    logic              wen;
    logic              clr;
    int                sel;
    logic [27:0]       raddr;
    logic [27:0]       waddr;
    logic [127:0]      wdata;
    logic [15:0]       strb;

    logic [c_NI-1:0]   ren_v;
    logic [c_NI-1:0]   wen_v;
    logic [c_NI-1:0]   clr_v;
    logic [c_NI-1:0]   mvalid;
    logic [c_NI-1:0]   oob;
    logic [127:0]      mdata [c_NI];
    logic [31:0]       rdc   [c_NI];
    logic [31:0]       wrc   [c_NI];

    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;
    int                q_due[$];
    logic [127:0]      q_dat[$];
    int                mon_due;
    logic [127:0]      mon_dat;

    // Instance 0: latency 1, old-data RAW, 1000 words
    // Instance 1: latency 3, merged RAW, 1024 words
    // Instance 2: latency 4, old-data RAW, 1024 words
    for (genvar g = 0; g < c_NI; g++) begin : g_dut
        localparam int c_L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        localparam int c_R = (g == 1) ? 1 : 0;
        localparam int c_D = (g == 0) ? 1000 : 1024;

        assign ren_v[g] = ren && (sel == g);
        assign wen_v[g] = wen && (sel == g);
        assign clr_v[g] = clr && (sel == g);

        dma_port_ram #(
            .AXI_WIDTH      (128),
            .AXI_ADDR_WIDTH (32),
            .DEPTH_WORDS    (c_D),
            .RD_LATENCY     (c_L),
            .RAW_MODE       (c_R)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .mm2s_ren   (ren_v[g]),
            .mm2s_addr  (raddr),
            .mm2s_data  (mdata[g]),
            .mm2s_valid (mvalid[g]),
            .s2mm_wen   (wen_v[g]),
            .s2mm_addr  (waddr),
            .s2mm_data  (wdata),
            .s2mm_strb  (strb),
            .clr_stats  (clr_v[g]),
            .rd_count   (rdc[g]),
            .wr_count   (wrc[g]),
            .oob_err    (oob[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(int s);
        return (s == 0) ? 1 : ((s == 1) ? 3 : 4);
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(int s, logic [127:0] d);
        q_due.push_back(cyc + lat(s));
        q_dat.push_back(d);
    endtask

    task automatic wr(int s, int a, logic [127:0] d, logic [15:0] st);
        sel = s; waddr = 28'(a); wdata = d; strb = st; wen = 1'b1;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(int s, int a, logic [127:0] e);
        sel = s; raddr = 28'(a); push(s, e); ren = 1'b1;
        tick();
        ren = 1'b0;
    endtask

    task automatic rw(int s, int ra, logic [127:0] e, int wa, logic [127:0] d);
        sel = s; raddr = 28'(ra); waddr = 28'(wa); wdata = d; strb = '1;
        push(s, e); ren = 1'b1; wen = 1'b1;
        tick();
        ren = 1'b0; wen = 1'b0;
    endtask

    // Monitor: every valid beat must match the oldest pending expectation.
    always @(negedge clk) begin
        for (int s = 0; s < c_NI; s++) begin
            if (mvalid[s] === 1'b1) begin
                if (q_due.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid inst=%0d actual=%0h required=no valid", s, mdata[s]);
                end else begin
                    mon_due = q_due.pop_front();
                    mon_dat = q_dat.pop_front();
                    chk("rd_cycle", 128'(cyc), 128'(mon_due));
                    chk("rd_data", mdata[s], mon_dat);
                end
            end
        end
    end

    localparam logic [127:0] c_D0   = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] c_ONES = '1;

    initial begin
        rst = 1'b1; ren = 1'b0; wen = 1'b0; clr = 1'b0; sel = 0;
        raddr = '0; waddr = '0; wdata = '0; strb = '0;
        idle(3);
        rst = 1'b0;
        for (int s = 0; s < c_NI; s++) begin
            chk("reset_valid", 128'(mvalid[s]), 128'd0);
            chk("reset_data", mdata[s], 128'd0);
            chk("reset_rd_count", 128'(rdc[s]), 128'd0);
            chk("reset_wr_count", 128'(wrc[s]), 128'd0);
            chk("reset_oob", 128'(oob[s]), 128'd0);
        end

        // Basic write/read, latency 1, then data holds after valid drops
        wr(0, 5, c_D0, 16'hFFFF);
        rd(0, 5, c_D0);
        idle(2);
        chk("basic_wr_count", 128'(wrc[0]), 128'd1);
        chk("basic_rd_count", 128'(rdc[0]), 128'd1);
        chk("data_hold", mdata[0], c_D0);

        // Partial strobe: bytes 4..7 replaced
        wr(0, 3, {16{8'hAA}}, 16'hFFFF);
        wr(0, 3, {16{8'h55}}, 16'h00F0);
        rd(0, 3, 128'hAAAAAAAA_AAAAAAAA_55555555_AAAAAAAA);

        // Read-during-write, old-data mode
        wr(0, 9, 128'd0, 16'hFFFF);
        rw(0, 9, 128'd0, 9, c_ONES);
        rd(0, 9, c_ONES);

        // Read-during-write, merged mode; different addresses independent
        wr(1, 9, 128'd0, 16'hFFFF);
        rw(1, 9, c_ONES, 9, c_ONES);
        rd(1, 9, c_ONES);
        wr(1, 10, 128'h1234, 16'hFFFF);
        rw(1, 10, 128'h1234, 11, 128'h5678);
        rd(1, 11, 128'h5678);
        idle(4);

        // Back-to-back reads at latency 3
        for (int i = 0; i < 8; i++) wr(1, i, 128'(i), 16'hFFFF);
        sel = 1;
        ren = 1'b1;
        for (int i = 0; i < 8; i++) begin
            raddr = 28'(i);
            push(1, 128'(i));
            tick();
        end
        ren = 1'b0;
        idle(5);

        // Out of range on the 1000-word instance
        wr(0, 999, 128'hCAFE, 16'hFFFF);
        wr(0, 1000, 128'hDEAD, 16'hFFFF);
        chk("oob_set", 128'(oob[0]), 128'd1);
        rd(0, 1000, 128'd0);
        rd(0, 999, 128'hCAFE);
        idle(2);
        chk("oob_wr_count", 128'(wrc[0]), 128'd7);
        chk("oob_rd_count", 128'(rdc[0]), 128'd6);
        sel = 0; raddr = 28'd1000; clr = 1'b1; ren = 1'b1;
        push(0, 128'd0);
        tick();
        clr = 1'b0; ren = 1'b0;
        chk("clr_oob", 128'(oob[0]), 128'd0);
        chk("clr_rd_count", 128'(rdc[0]), 128'd0);
        chk("clr_wr_count", 128'(wrc[0]), 128'd0);
        idle(2);

        // Reset mid-read at latency 4; write during reset is ignored
        wr(2, 20, 128'hA5A5, 16'hFFFF);
        wr(2, 21, 128'h0F0F, 16'hFFFF);
        sel = 2; raddr = 28'd20; ren = 1'b1;
        idle(2);
        ren = 1'b0;
        rst = 1'b1; waddr = 28'd21; wdata = 128'hBAD; strb = '1; wen = 1'b1;
        tick();
        rst = 1'b0; wen = 1'b0;
        chk("rst_rd_count", 128'(rdc[2]), 128'd0);
        chk("rst_wr_count", 128'(wrc[2]), 128'd0);
        chk("rst_data", mdata[2], 128'd0);
        rd(2, 20, 128'hA5A5);
        rd(2, 21, 128'h0F0F);
        idle(8);

        chk("pending_reads", 128'(q_due.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
